// File: rtl/bus_pkg.sv
// Shared types and codes for the bus arbiter and its round-robin picker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester -> arbiter and arbiter -> target send codes
  localparam logic [1:0] SEND_IDLE = 2'b00;
  localparam logic [1:0] SEND_REQ  = 2'b01;

  // Completion codes returned to requesters
  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_OK   = 2'b01;
  localparam logic [1:0] ACK_ERR  = 2'b10;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_picker.sv
// Round-robin one-hot picker: first requester strictly above last_owner, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; pick is valid whenever any request bit is set.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last_owner,  // one-hot
  output logic [N_REQ-1:0] pick,        // one-hot
  output logic             vld
);

  logic [N_REQ-1:0] above;
  logic [N_REQ-1:0] req_hi;

  // Bits strictly above the one-hot last owner get first look; if none of
  // them request, wrap around and take the lowest requesting bit overall.
  assign above  = ~(last_owner | (last_owner - N_REQ'(1)));
  assign req_hi = req & above;
  assign pick   = (req_hi != '0) ? (req_hi & (~req_hi + N_REQ'(1)))
                                 : (req & (~req + N_REQ'(1)));
  assign vld    = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting N_REQ requesters one shared target bus.
// Latency: request to bus_send/grant 1 cycle; min 1 idle cycle between transactions.
// Backpressure: holds bus_send until bus_ack or TIMEOUT; holds req_ack until owner drops req_send.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*N_REQ-1:0]      req_send,
  input  logic [DATA_W*N_REQ-1:0] req_dado,
  output logic [2*N_REQ-1:0]      req_ack,
  output logic [N_REQ-1:0]        grant,
  output logic [1:0]              bus_send,
  output logic [DATA_W-1:0]       bus_dado,
  input  logic [1:0]              bus_ack,
  output logic                    busy
);

  // Requester 0 has first priority out of reset
  localparam logic [N_REQ-1:0] LAST_RST = N_REQ'(1) << (N_REQ - 1);

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic [2*N_REQ-1:0]  req_ack_nxt;
  logic [1:0]          bus_send_nxt;
  logic [DATA_W-1:0]   bus_dado_nxt;
  logic                busy_nxt;
  logic [7:0]          wait_cnt, wait_cnt_nxt, wait_cnt_inc;
  logic [N_REQ-1:0]    last_owner, last_owner_nxt;

  logic [N_REQ-1:0]    req_vec;
  logic [N_REQ-1:0]    pick;
  logic                pick_vld;
  logic [DATA_W-1:0]   pick_dat;
  logic                owner_req;
  logic [1:0]          bus_status;
  logic [2*N_REQ-1:0]  ack_spread;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req        (req_vec),
    .last_owner (last_owner),
    .pick       (pick),
    .vld        (pick_vld)
  );

  // Decode send codes, mux the picked word, and route status to the owner slice
  always_comb begin
    req_vec    = '0;
    pick_dat   = '0;
    ack_spread = '0;
    bus_status = (bus_ack == ACK_OK) ? ACK_OK : ACK_ERR;
    for (int i = 0; i < N_REQ; i++) begin
      req_vec[i] = (req_send[2*i +: 2] == SEND_REQ);
      if (pick[i]) pick_dat = pick_dat | req_dado[DATA_W*i +: DATA_W];
      if (grant[i]) ack_spread[2*i +: 2] = bus_status;
    end
  end

  assign owner_req    = |(grant & req_vec);
  assign wait_cnt_inc = wait_cnt + 8'd1;

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    req_ack_nxt    = req_ack;
    bus_send_nxt   = bus_send;
    bus_dado_nxt   = bus_dado;
    busy_nxt       = busy;
    wait_cnt_nxt   = wait_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = BUS;
          grant_nxt    = pick;
          bus_dado_nxt = pick_dat;
          bus_send_nxt = SEND_REQ;
          wait_cnt_nxt = '0;
          busy_nxt     = 1'b1;
        end
      end
      BUS: begin
        // A silent target counts as an error once TIMEOUT idle cycles pass
        if ((bus_ack != ACK_NONE) || (wait_cnt_inc == 8'(TIMEOUT))) begin
          state_nxt    = DONE;
          bus_send_nxt = SEND_IDLE;
          req_ack_nxt  = ack_spread;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
        end
      end
      DONE: begin
        // Completion is held until the owner withdraws its request
        if (!owner_req) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          req_ack_nxt    = '0;
          last_owner_nxt = grant;
          busy_nxt       = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        grant_nxt    = '0;
        req_ack_nxt  = '0;
        bus_send_nxt = SEND_IDLE;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      req_ack    <= '0;
      bus_send   <= SEND_IDLE;
      bus_dado   <= '0;
      busy       <= 1'b0;
      wait_cnt   <= '0;
      last_owner <= LAST_RST;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      req_ack    <= req_ack_nxt;
      bus_send   <= bus_send_nxt;
      bus_dado   <= bus_dado_nxt;
      busy       <= busy_nxt;
      wait_cnt   <= wait_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with default parameters.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays the target and drives bus_ack directly.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req_send;
  logic [63:0] req_dado;
  logic [7:0]  req_ack;
  logic [3:0]  grant;
  logic [1:0]  bus_send;
  logic [15:0] bus_dado;
  logic [1:0]  bus_ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(
    .N_REQ   (4),
    .DATA_W  (16),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_send (req_send),
    .req_dado (req_dado),
    .req_ack  (req_ack),
    .grant    (grant),
    .bus_send (bus_send),
    .bus_dado (bus_dado),
    .bus_ack  (bus_ack),
    .busy     (busy)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_send = '0; req_dado = '0; bus_ack = 2'b00;
    #12;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b want=%b", grant, 4'b0000); end
    checks++; if (req_ack !== 8'h00) begin errors++; $display("FAIL reset_req_ack got=%h want=%h", req_ack, 8'h00); end
    checks++; if (bus_send !== 2'b00) begin errors++; $display("FAIL reset_bus_send got=%b want=%b", bus_send, 2'b00); end
    checks++; if (bus_dado !== 16'h0000) begin errors++; $display("FAIL reset_bus_dado got=%h want=%h", bus_dado, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=%b", busy, 1'b0); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single;
    req_dado[15:0] = 16'hA5A5;
    req_send[1:0]  = 2'b01;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b want=%b", grant, 4'b0001); end
    checks++; if (bus_send !== 2'b01) begin errors++; $display("FAIL single_bus_send got=%b want=%b", bus_send, 2'b01); end
    checks++; if (bus_dado !== 16'hA5A5) begin errors++; $display("FAIL single_bus_dado got=%h want=%h", bus_dado, 16'hA5A5); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=%b", busy, 1'b1); end
    tick(); tick();
    checks++; if (bus_send !== 2'b01) begin errors++; $display("FAIL single_wait_send got=%b want=%b", bus_send, 2'b01); end
    checks++; if (req_ack !== 8'h00) begin errors++; $display("FAIL single_wait_ack got=%h want=%h", req_ack, 8'h00); end
    bus_ack = 2'b01;
    tick();
    bus_ack = 2'b00;
    checks++; if (req_ack !== 8'h01) begin errors++; $display("FAIL single_done_ack got=%h want=%h", req_ack, 8'h01); end
    checks++; if (bus_send !== 2'b00) begin errors++; $display("FAIL single_done_send got=%b want=%b", bus_send, 2'b00); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_done_grant got=%b want=%b", grant, 4'b0001); end
    tick();
    checks++; if (req_ack !== 8'h01) begin errors++; $display("FAIL single_hold_ack got=%h want=%h", req_ack, 8'h01); end
    req_send[1:0] = 2'b00;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release_grant got=%b want=%b", grant, 4'b0000); end
    checks++; if (req_ack !== 8'h00) begin errors++; $display("FAIL single_release_ack got=%h want=%h", req_ack, 8'h00); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_release_busy got=%b want=%b", busy, 1'b0); end
  endtask

  task automatic test_contention;
    int order [4];
    int r;
    logic [3:0] exp_grant;
    logic [7:0] exp_ack;
    order = '{0, 2, 3, 0};
    rst = 1'b0;
    #2;
    rst = 1'b1;
    req_send = 8'h51;  // requesters 0, 2 and 3
    for (int t = 0; t < 4; t++) begin
      r = order[t];
      exp_grant = 4'(1 << r);
      exp_ack   = 8'(1 << (2 * r));
      tick();
      checks++; if (grant !== exp_grant) begin errors++; $display("FAIL contention_grant[%0d] got=%b want=%b", t, grant, exp_grant); end
      bus_ack = 2'b01;
      tick();
      bus_ack = 2'b00;
      checks++; if (req_ack !== exp_ack) begin errors++; $display("FAIL contention_ack[%0d] got=%h want=%h", t, req_ack, exp_ack); end
      req_send[2*r +: 2] = 2'b00;
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL contention_release[%0d] got=%b want=%b", t, grant, 4'b0000); end
      if (t == 0) req_send[1:0] = 2'b01;
    end
  endtask

  task automatic test_timeout;
    req_send = 8'h04;  // requester 1
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL timeout_grant got=%b want=%b", grant, 4'b0010); end
    repeat (14) tick();
    checks++; if (bus_send !== 2'b01) begin errors++; $display("FAIL timeout_cycle14_send got=%b want=%b", bus_send, 2'b01); end
    checks++; if (req_ack !== 8'h00) begin errors++; $display("FAIL timeout_cycle14_ack got=%h want=%h", req_ack, 8'h00); end
    tick();
    checks++; if (req_ack !== 8'h08) begin errors++; $display("FAIL timeout_ack got=%h want=%h", req_ack, 8'h08); end
    checks++; if (bus_send !== 2'b00) begin errors++; $display("FAIL timeout_send got=%b want=%b", bus_send, 2'b00); end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL timeout_done_grant got=%b want=%b", grant, 4'b0010); end
    req_send = 8'h00;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL timeout_release got=%b want=%b", grant, 4'b0000); end
  endtask

  task automatic test_error;
    req_send = 8'h50;  // requesters 2 and 3; last owner was 1
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL error_grant got=%b want=%b", grant, 4'b0100); end
    bus_ack = 2'b10;
    tick();
    bus_ack = 2'b00;
    checks++; if (req_ack !== 8'h20) begin errors++; $display("FAIL error_ack got=%h want=%h", req_ack, 8'h20); end
    checks++; if (bus_send !== 2'b00) begin errors++; $display("FAIL error_send got=%b want=%b", bus_send, 2'b00); end
    req_send[5:4] = 2'b00;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL error_release got=%b want=%b", grant, 4'b0000); end
    tick();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL error_next_grant got=%b want=%b", grant, 4'b1000); end
    checks++; if (bus_send !== 2'b01) begin errors++; $display("FAIL error_next_send got=%b want=%b", bus_send, 2'b01); end
    bus_ack = 2'b01;
    tick();
    bus_ack = 2'b00;
    checks++; if (req_ack !== 8'h40) begin errors++; $display("FAIL error_next_ack got=%h want=%h", req_ack, 8'h40); end
    req_send = 8'h00;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL error_next_release got=%b want=%b", grant, 4'b0000); end
  endtask

  task automatic test_reset_mid;
    req_dado[31:16] = 16'hBEEF;
    req_send = 8'h04;  // requester 1
    tick();
    checks++; if (bus_send !== 2'b01) begin errors++; $display("FAIL rstmid_pre_send got=%b want=%b", bus_send, 2'b01); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant got=%b want=%b", grant, 4'b0000); end
    checks++; if (bus_send !== 2'b00) begin errors++; $display("FAIL rstmid_send got=%b want=%b", bus_send, 2'b00); end
    checks++; if (bus_dado !== 16'h0000) begin errors++; $display("FAIL rstmid_dado got=%h want=%h", bus_dado, 16'h0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=%b", busy, 1'b0); end
    checks++; if (req_ack !== 8'h00) begin errors++; $display("FAIL rstmid_ack got=%h want=%h", req_ack, 8'h00); end
    req_send = 8'h41;  // requesters 0 and 3
    #2;
    rst = 1'b1;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rstmid_after_grant got=%b want=%b", grant, 4'b0001); end
    bus_ack = 2'b01;
    tick();
    bus_ack = 2'b00;
    checks++; if (req_ack !== 8'h01) begin errors++; $display("FAIL rstmid_after_ack got=%h want=%h", req_ack, 8'h01); end
    req_send = 8'h00;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rstmid_after_release got=%b want=%b", grant, 4'b0000); end
  endtask

  task automatic test_data_stable;
    req_dado[47:32] = 16'h1234;
    req_send = 8'h10;  // requester 2
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stable_grant got=%b want=%b", grant, 4'b0100); end
    checks++; if (bus_dado !== 16'h1234) begin errors++; $display("FAIL stable_latch got=%h want=%h", bus_dado, 16'h1234); end
    req_dado[47:32] = 16'hFFFF;
    req_send = 8'h00;
    tick();
    checks++; if (bus_dado !== 16'h1234) begin errors++; $display("FAIL stable_bus_dado got=%h want=%h", bus_dado, 16'h1234); end
    checks++; if (bus_send !== 2'b01) begin errors++; $display("FAIL stable_bus_send got=%b want=%b", bus_send, 2'b01); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stable_grant_held got=%b want=%b", grant, 4'b0100); end
    bus_ack = 2'b01;
    tick();
    bus_ack = 2'b00;
    checks++; if (bus_dado !== 16'h1234) begin errors++; $display("FAIL stable_done_dado got=%h want=%h", bus_dado, 16'h1234); end
    checks++; if (req_ack !== 8'h10) begin errors++; $display("FAIL stable_done_ack got=%h want=%h", req_ack, 8'h10); end
    checks++; if (bus_send !== 2'b00) begin errors++; $display("FAIL stable_done_send got=%b want=%b", bus_send, 2'b00); end
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stable_exit_grant got=%b want=%b", grant, 4'b0000); end
    checks++; if (req_ack !== 8'h00) begin errors++; $display("FAIL stable_exit_ack got=%h want=%h", req_ack, 8'h00); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stable_exit_busy got=%b want=%b", busy, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_error();
    test_reset_mid();
    test_data_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of processor requesters.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent waiting for bus_ack (range 1..255).
REQ-004 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 Port rst  input  1: asynchronous active-low reset.
REQ-006 Port req_send  input  2*N_REQ: per-requester send code; 2'b01 = request, 2'b00 = idle, other codes = idle.
REQ-007 Port req_dado  input  DATA_W*N_REQ: per-requester data word; slice i belongs to requester i.
REQ-008 Port req_ack  output  2*N_REQ: per-requester completion code; 2'b01 = done ok, 2'b10 = error, 2'b00 = none.
REQ-009 Port grant  output  N_REQ: one-hot owner of the shared bus, or all zero.
REQ-010 Port bus_send  output  2: send code to the shared target; 2'b01 = valid, 2'b00 = idle.
REQ-011 Port bus_dado  output  DATA_W: data to the shared target.
REQ-012 Port bus_ack  input  2: target response; 2'b01 = accept, 2'b10 or 2'b11 = error, 2'b00 = none.
REQ-013 Port busy  output  1: high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUS and DONE. All outputs SHALL be registered.
REQ-015 In IDLE, when any req_send slice is 2'b01, the block SHALL select one requester by round-robin priority, starting at last_owner+1 and wrapping modulo N_REQ.
REQ-016 The block SHALL enter BUS on the next edge. On that same edge it SHALL set grant, latch the owner's req_dado into bus_dado, and drive bus_send=2'b01. The request-to-bus_send latency is 1 cycle.
REQ-017 In BUS, bus_dado SHALL hold the latched word. A requester changing req_dado or dropping req_send SHALL NOT abort or alter the transaction.
REQ-018 In BUS, bus_ack=2'b01 SHALL set status to 2'b01. bus_ack=2'b10 or 2'b11 SHALL set status to 2'b10. Either case SHALL move the FSM to DONE on that edge.
REQ-019 In BUS, a wait counter SHALL count cycles with bus_ack=2'b00. When it reaches TIMEOUT, status SHALL be 2'b10 and the FSM SHALL move to DONE. The counter SHALL clear on entry to BUS.
REQ-020 In DONE:
  - bus_send SHALL be 2'b00.
  - The owner's req_ack slice SHALL hold status; all other slices SHALL be 2'b00.
  - grant SHALL remain asserted.
REQ-021 The FSM SHALL stay in DONE until the owner's req_send is not 2'b01. On the edge that sees this, it SHALL:
  - clear grant and req_ack;
  - set last_owner to the owner;
  - return to IDLE.
REQ-022 bus_ack SHALL be ignored outside BUS. Requests from non-owners SHALL be ignored outside IDLE.
REQ-023 The earliest a new grant can be issued is the edge after the return to IDLE. This gives a minimum gap of 1 idle cycle between bus transactions.
REQ-024 When several requesters are already waiting, each SHALL be served within N_REQ transactions; no requester starves.

Reset
REQ-025 When rst=0, the block SHALL, asynchronously:
  - set state to IDLE;
  - clear grant, req_ack, bus_send, bus_dado, busy and the wait counter;
  - set last_owner to N_REQ-1, so requester 0 has first priority.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction. No req_ack SHALL be issued for it.

Structure
REQ-027 Shared package bus_pkg SHALL hold:
  - the state enum (IDLE, BUS, DONE);
  - the send codes SEND_IDLE and SEND_REQ;
  - the ack codes ACK_NONE, ACK_OK and ACK_ERR;
  - the defaults for DATA_W and TIMEOUT.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_picker. Its inputs are the request vector and last_owner; its outputs are a one-hot pick and a valid flag.

Verification
REQ-029 Single request: after reset, req_send[0]=01 with req_dado[0]=16'hA5A5, and target acks 01 three cycles later.
  - Required: 1 cycle later grant=0001, bus_send=01, bus_dado=A5A5.
  - Required: then req_ack[0]=01 until req_send[0] drops, then grant=0.
REQ-030 Contention: requesters 0, 2 and 3 all request together from reset, and each holds req_send=01 until it receives req_ack.
  - Required: grant order 0, 2, 3; with requester 0 requesting again, the next grant goes to 0 after 3.
REQ-031 Timeout with TIMEOUT=15: requester 1 is granted and bus_ack stays 00.
  - Required: after 15 cycles in BUS, req_ack[1]=10 and bus_send=00.
REQ-032 Target error: bus_ack=10 in the first BUS cycle.
  - Required: req_ack of the owner =10; the next requester is served normally.
REQ-033 Reset mid-BUS: rst=0 while bus_send=01.
  - Required: all outputs 0 immediately; after release, requester 0 wins a contention with requester 3.
REQ-034 Data stability: the owner changes req_dado and drops req_send during BUS.
  - Required: bus_dado keeps the latched word until DONE; DONE exits on the first edge after entry.
